temporal_gemm_unit: RTL
=======================

// Module: temporal_gemm_unit
// PURPOSE
//  Parametrised temporal (unary-stream) GEMM engine: out = alpha*(A x B) + beta*C for
//  A (M x K), B (K x N) and C (M x N), in unsigned or two's-complement mode. Each B element is
//  applied as a unary stream, so a product costs cycles rather than multipliers. Early
//  termination bounds run time by the largest |B|; out_valid/out_ready provides backpressure.
//  Successor to temporal_mxu (square, unsigned only, no backpressure); sits under the matrix
//  datapath controller.
// PARAMETERS
//  BIT_WIDTH   4  element/alpha/beta width
//  M           2  rows of A, C, out
//  K           2  cols of A = rows of B (reduction depth)
//  N           2  cols of B, C, out
//  SIGNED      0  0: unsigned operands; 1: two's-complement operands and result
//  EARLY_TERM  1  1: stream length L = max|B|; 0: L = 2^BIT_WIDTH (SIGNED=0) or 2^(BIT_WIDTH-1) (SIGNED=1)
//  localparam OUT_W = 3*BIT_WIDTH + $clog2(K) + 1
// PORTS
//  clk        in   1                  clock; all state updates on rising edge
//  reset_n    in   1                  asynchronous active-low reset
//  start      in   1                  request; sampled only in IDLE
//  A          in   [M][K][BIT_WIDTH]  left operand, captured when start is accepted
//  B          in   [K][N][BIT_WIDTH]  right operand, captured when start is accepted
//  C          in   [M][N][BIT_WIDTH]  addend matrix, captured when start is accepted
//  alpha      in   BIT_WIDTH          product scale, captured when start is accepted
//  beta       in   BIT_WIDTH          addend scale, captured when start is accepted
//  out_ready  in   1                  consumer accepts out when high with out_valid
//  busy       out  1                  high in every state except IDLE
//  out_valid  out  1                  result valid; held until accepted
//  out        out  [M][N][OUT_W]      result; signed iff SIGNED=1; stable while out_valid
// BEHAVIOUR
//  Reset (asynchronous, any state, including mid-STREAM): state=IDLE; busy=0; out_valid=0;
//    out=0; accumulators, counter and captured operands cleared; the in-flight job is dropped.
//  FSM: IDLE -> PREP -> STREAM -> SCALE1 -> SCALE2 -> DONE -> IDLE.
//   IDLE:   on start=1, capture A, B, C, alpha, beta and go to PREP. Otherwise stay.
//   PREP:   clear acc[M][N]; cnt=0; compute L from the captured B.
//           Go to STREAM if L>0, else to SCALE1.
//   STREAM: each cycle, for all i,j,k with cnt < |B[k][j]|, acc[i][j] += sgn(B[k][j])*A[i][k]
//           (A sign-extended when SIGNED=1). Then cnt++. Go to SCALE1 after the cycle with cnt==L-1.
//   SCALE1: prod[i][j] = alpha*acc[i][j] (registered).
//   SCALE2: out[i][j] = prod[i][j] + beta*C[i][j] (registered); go to DONE.
//   DONE:   out_valid=1. On out_ready=1, go to IDLE; out_valid drops next cycle and out holds
//           its value.
//  Latency: out_valid rises exactly L+3 rising edges after the edge that accepts start.
//  Arithmetic: |x| for SIGNED=1 uses a BIT_WIDTH-bit unsigned magnitude, so |-2^(W-1)| =
//    2^(W-1) is exact. All sums are full-width in OUT_W, so no overflow or saturation occurs.
//  start while busy (including in DONE with out_ready=1) is ignored and never queued.
//    Input changes after capture do not affect the result.
//  L=0 (B all zero, EARLY_TERM=1): STREAM is skipped, out = beta*C, latency 3.
// TESTING
//  1. W=4, 2x2x2, unsigned, A=B=all 1, C=[1,2;4,15], alpha=2, beta=1 -> out=[5,6;8,19];
//     out_valid 4 edges after start.
//  2. SIGNED=1, A=[-1,2;3,-8], B=[-8,1;0,7], alpha=1, beta=0 -> out=[8,13;-24,-53];
//     L=8, out_valid after 11 edges.
//  3. EARLY_TERM=0, unsigned, A=B=C=all 15, alpha=beta=15 -> out all 6975; out_valid after 19 edges.
//  4. B all 0, C=all 3, beta=2 -> out all 6, out_valid after 3 edges. Hold out_ready=0 for
//     5 cycles -> out_valid and out stable throughout; IDLE one edge after out_ready=1.
//  5. start pulsed again during STREAM with different A -> ignored; result matches the first
//     operands; busy stays 1.
//  6. reset_n low mid-STREAM -> busy=0, out_valid=0, out=0 at once. Then a new start
//     completes correctly with no residue from the dropped job.

Source files
------------

// File: rtl/temporal_gemm_unit.sv
// temporal_gemm_unit
//   Temporal (unary-stream) GEMM engine computing out = alpha*(A x B) + beta*C.
//   Each B element is consumed as a unary stream: for |B[k][j]| cycles the
//   matching column of A is added (or subtracted, for negative B) into the
//   accumulator, so products cost cycles rather than multipliers. With early
//   termination the stream length is the largest |B| of the captured job.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset; drops any in-flight job
//   start      job request, sampled only while idle
//   A,B,C      operand matrices, captured when start is accepted
//   alpha,beta scale factors, captured when start is accepted
//   out_ready  consumer handshake for out/out_valid
//   busy       high whenever a job is in flight (any state but IDLE)
//   out_valid  result valid, held until out_ready
//   out        result matrix, signed when SIGNED=1, stable while out_valid
module temporal_gemm_unit #(
   parameter  int BIT_WIDTH  = 4,
   parameter  int M          = 2,
   parameter  int K          = 2,
   parameter  int N          = 2,
   parameter  int SIGNED     = 0,
   parameter  int EARLY_TERM = 1,
   localparam int OUT_W      = 3*BIT_WIDTH + $clog2(K) + 1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic [M-1:0][K-1:0][BIT_WIDTH-1:0]  A,
   input  logic [K-1:0][N-1:0][BIT_WIDTH-1:0]  B,
   input  logic [M-1:0][N-1:0][BIT_WIDTH-1:0]  C,
   input  logic [BIT_WIDTH-1:0]                alpha,
   input  logic [BIT_WIDTH-1:0]                beta,
   input  logic                                out_ready,
   output logic                                busy,
   output logic                                out_valid,
   output logic [M-1:0][N-1:0][OUT_W-1:0]      out
);

   localparam logic SX = (SIGNED != 0);
   localparam logic ET = (EARLY_TERM != 0);
   // Fixed stream length when early termination is off: covers the full
   // magnitude range of a B element.
   localparam logic [BIT_WIDTH:0] FULL_LEN = SX ? ((BIT_WIDTH+1)'(1) << (BIT_WIDTH-1))
                                                : ((BIT_WIDTH+1)'(1) << BIT_WIDTH);

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_STREAM, S_SCALE1, S_SCALE2, S_DONE
   } state_t;

   state_t                               state_q, state_d;
   logic [M-1:0][K-1:0][BIT_WIDTH-1:0]   a_q, a_d;
   logic [K-1:0][N-1:0][BIT_WIDTH-1:0]   b_q, b_d;
   logic [M-1:0][N-1:0][BIT_WIDTH-1:0]   c_q, c_d;
   logic [BIT_WIDTH-1:0]                 alpha_q, alpha_d;
   logic [BIT_WIDTH-1:0]                 beta_q, beta_d;
   logic [BIT_WIDTH:0]                   len_q, len_d;
   logic [BIT_WIDTH:0]                   cnt_q, cnt_d;
   logic [M-1:0][N-1:0][OUT_W-1:0]       acc_q, acc_d;
   logic [M-1:0][N-1:0][OUT_W-1:0]       prod_q, prod_d;
   logic [M-1:0][N-1:0][OUT_W-1:0]       out_q, out_d;

   logic signed [OUT_W-1:0]              sum;
   logic [BIT_WIDTH:0]                   max_mag;

   // Operand widened to OUT_W: sign-extended in signed mode, zero-extended otherwise.
   function automatic logic signed [OUT_W-1:0] ext(input logic [BIT_WIDTH-1:0] x);
      ext = $signed({{(OUT_W-BIT_WIDTH){x[BIT_WIDTH-1] & SX}}, x});
   endfunction

   // Unsigned magnitude; the most negative value maps exactly to 2^(W-1).
   function automatic logic [BIT_WIDTH-1:0] mag(input logic [BIT_WIDTH-1:0] x);
      mag = (SX && x[BIT_WIDTH-1]) ? (~x + 1'b1) : x;
   endfunction

   function automatic logic is_neg(input logic [BIT_WIDTH-1:0] x);
      is_neg = SX & x[BIT_WIDTH-1];
   endfunction

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      alpha_d = alpha_q;
      beta_d  = beta_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      out_d   = out_q;
      sum     = '0;
      max_mag = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               c_d     = C;
               alpha_d = alpha;
               beta_d  = beta;
               state_d = S_PREP;
            end
         end

         S_PREP: begin
            for (int k = 0; k < K; k++) begin
               for (int j = 0; j < N; j++) begin
                  if ({1'b0, mag(b_q[k][j])} > max_mag) max_mag = {1'b0, mag(b_q[k][j])};
               end
            end
            acc_d   = '0;
            cnt_d   = '0;
            len_d   = ET ? max_mag : FULL_LEN;
            state_d = (len_d != '0) ? S_STREAM : S_SCALE1;
         end

         S_STREAM: begin
            // One unary step: every B element whose magnitude exceeds the
            // step count still contributes one copy of its A column.
            for (int i = 0; i < M; i++) begin
               for (int j = 0; j < N; j++) begin
                  sum = $signed(acc_q[i][j]);
                  for (int k = 0; k < K; k++) begin
                     if ({1'b0, mag(b_q[k][j])} > cnt_q) begin
                        if (is_neg(b_q[k][j])) sum = sum - ext(a_q[i][k]);
                        else                   sum = sum + ext(a_q[i][k]);
                     end
                  end
                  acc_d[i][j] = sum;
               end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) state_d = S_SCALE1;
         end

         S_SCALE1: begin
            for (int i = 0; i < M; i++) begin
               for (int j = 0; j < N; j++) begin
                  prod_d[i][j] = ext(alpha_q) * $signed(acc_q[i][j]);
               end
            end
            state_d = S_SCALE2;
         end

         S_SCALE2: begin
            for (int i = 0; i < M; i++) begin
               for (int j = 0; j < N; j++) begin
                  out_d[i][j] = $signed(prod_q[i][j]) + ext(beta_q) * ext(c_q[i][j]);
               end
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         alpha_q <= '0;
         beta_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         alpha_q <= alpha_d;
         beta_q  <= beta_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         out_q   <= out_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out       = out_q;

endmodule
